// File: rtl/tlp_tap_fifo_writer_if.sv
// Tap stream plus FIFO write port of the TLP tap writer; master is the writer side,
// slave is the tap source and FIFO together.
interface tlp_tap_fifo_writer_if;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic        prog_full;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    input  full, prog_full,
    output wr_en, din
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
    output full, prog_full,
    input  wr_en, din
  );
endinterface

// File: rtl/tlp_tap_fifo_writer.sv
// Normalises tapped TLPs into fixed REC_BEATS x 64-bit records in two ping-pong slots and bursts
// each whole record into the FIFO; first write two cycles after tlast, full stalls, prog_full gates start.
module tlp_tap_fifo_writer #(
  parameter int TLP_LEN   = 32,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic                         clk156,
  input  logic                         sys_rst,
  input  logic                         enable,
  tlp_tap_fifo_writer_if.master        bus,
  output logic [31:0]                  cnt_tlp,
  output logic [31:0]                  cnt_drop,
  output logic [31:0]                  cnt_trunc
);
  localparam int REC_BEATS = TLP_LEN / 8;
  localparam int IW = (REC_BEATS > 1) ? $clog2(REC_BEATS) : 1;
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(REC_BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(REC_BEATS);

  typedef enum logic {F_IDLE, F_WRITE} fstate_t;

  fstate_t       state_q;
  logic          fl_slot_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    busy_q, ready_q, err_q;
  logic          head_q;
  logic [CW-1:0] fill_q [2];
  logic [63:0]   mem_q [2][REC_BEATS];
  logic          in_pkt_q, cap_q, cap_slot_q, trunc_q;
  logic [31:0]   cnt_tlp_q, cnt_drop_q, cnt_trunc_q;

  logic          fin_wr, free0, free1, sof, sof_take, sof_drop, new_slot, wr_slot;
  logic          cap_beat, mem_we, beat_trunc, trunc_now, launch, pick, rd_last;
  logic [CW-1:0] beat_k;
  logic [63:0]   masked, rd_word;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [63:0] swap64(input logic [63:0] w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*(7-b) +: 8] = w[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    fin_wr   = (state_q == F_WRITE) && !bus.full && (idx_q == LAST_IDX);
    // A slot whose last beat leaves this cycle is already available to a new SOF.
    free0    = !busy_q[0] || (fin_wr && !fl_slot_q);
    free1    = !busy_q[1] || (fin_wr && fl_slot_q);
    sof      = bus.s_axis_tvalid && !in_pkt_q;
    sof_take = sof && enable && (free0 || free1);
    sof_drop = sof && enable && !(free0 || free1);
    new_slot = !free0;
    cap_beat = sof ? sof_take : (bus.s_axis_tvalid && cap_q);
    wr_slot  = sof ? new_slot : cap_slot_q;
    beat_k   = sof ? '0 : fill_q[cap_slot_q];
    mem_we   = cap_beat && (beat_k != FULL_CNT);
    beat_trunc = cap_beat && (beat_k == FULL_CNT);
    trunc_now  = (trunc_q && !sof) || beat_trunc;
    for (int b = 0; b < 8; b++)
      masked[8*b +: 8] = bus.s_axis_tkeep[b] ? bus.s_axis_tdata[8*b +: 8] : 8'h00;
    launch   = (state_q == F_IDLE) && (ready_q != 2'b00) && !bus.prog_full;
    pick     = (&ready_q) ? head_q : ready_q[1];
    // Beats past the captured length read as zero instead of clearing the slot.
    rd_word  = ({1'b0, idx_q} < fill_q[fl_slot_q]) ? mem_q[fl_slot_q][idx_q] : '0;
    rd_last  = (idx_q == LAST_IDX);
  end

  always_comb begin
    bus.wr_en = (state_q == F_WRITE) && !bus.full && !sys_rst;
    bus.din   = '0;
    if (state_q == F_WRITE)
      bus.din = {8'hFF, (BYTE_SWAP ? swap64(rd_word) : rd_word), rd_last, err_q[fl_slot_q] & rd_last};
  end

  always_ff @(posedge clk156) begin
    if (mem_we) mem_q[wr_slot][beat_k[IW-1:0]] <= masked;
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q     <= F_IDLE;
      fl_slot_q   <= 1'b0;
      idx_q       <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      err_q       <= '0;
      head_q      <= 1'b0;
      fill_q[0]   <= '0;
      fill_q[1]   <= '0;
      in_pkt_q    <= 1'b0;
      cap_q       <= 1'b0;
      cap_slot_q  <= 1'b0;
      trunc_q     <= 1'b0;
      cnt_tlp_q   <= '0;
      cnt_drop_q  <= '0;
      cnt_trunc_q <= '0;
    end else begin
      if (bus.s_axis_tvalid) in_pkt_q <= !bus.s_axis_tlast;
      if (sof) cap_q <= sof_take;
      if (sof_drop) cnt_drop_q <= sat_inc(cnt_drop_q);

      unique case (state_q)
        F_IDLE: begin
          if (launch) begin
            state_q        <= F_WRITE;
            fl_slot_q      <= pick;
            idx_q          <= '0;
            ready_q[pick]  <= 1'b0;
          end
        end
        F_WRITE: begin
          if (!bus.full) begin
            if (idx_q == LAST_IDX) begin
              state_q           <= F_IDLE;
              busy_q[fl_slot_q] <= 1'b0;
              cnt_tlp_q         <= sat_inc(cnt_tlp_q);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
      endcase

      // Capture updates come after the flush so a bypassed slot ends up busy again.
      if (sof_take) begin
        busy_q[new_slot] <= 1'b1;
        cap_slot_q       <= new_slot;
        fill_q[new_slot] <= CW'(1);
        err_q[new_slot]  <= bus.s_axis_tuser;
        trunc_q          <= 1'b0;
      end else if (cap_beat) begin
        if (mem_we) fill_q[cap_slot_q] <= fill_q[cap_slot_q] + CW'(1);
        err_q[cap_slot_q] <= err_q[cap_slot_q] | bus.s_axis_tuser | beat_trunc;
        trunc_q           <= trunc_q | beat_trunc;
      end

      if (cap_beat && bus.s_axis_tlast) begin
        ready_q[wr_slot] <= 1'b1;
        head_q <= (ready_q[~wr_slot] && !(launch && (pick == ~wr_slot))) ? ~wr_slot : wr_slot;
        if (trunc_now) cnt_trunc_q <= sat_inc(cnt_trunc_q);
      end
    end
  end

  assign cnt_tlp   = cnt_tlp_q;
  assign cnt_drop  = cnt_drop_q;
  assign cnt_trunc = cnt_trunc_q;
endmodule

// File: tb/tb_tlp_tap_fifo_writer.sv
// Scoreboard bench for tlp_tap_fifo_writer: byte-level record model feeds an expected-beat
// queue, an output monitor pops and compares every FIFO write.
module tb_tlp_tap_fifo_writer;
  localparam int TLP_LEN = 32;
  localparam int REC     = TLP_LEN / 8;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [31:0] cnt_tlp, cnt_drop, cnt_trunc;

  tlp_tap_fifo_writer_if bus();

  tlp_tap_fifo_writer #(.TLP_LEN(TLP_LEN), .BYTE_SWAP(1'b1)) dut (
    .clk156    (clk156),
    .sys_rst   (sys_rst),
    .enable    (enable),
    .bus       (bus),
    .cnt_tlp   (cnt_tlp),
    .cnt_drop  (cnt_drop),
    .cnt_trunc (cnt_trunc)
  );

  always #5 clk156 = ~clk156;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [73:0] exp_q[$];
  int occ = 0, wpos = 0, first_cyc = 0, last_cyc = 0;
  logic [73:0] first_din = '0, last_din = '0;
  int m_pushed = 0, m_drop = 0, m_trunc = 0, m_nb = 0;
  bit m_inpkt = 0, m_cap = 0, m_err = 0, rand_bp = 0;
  logic [7:0] m_bytes [TLP_LEN];

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk156) cyc = cyc + 1;

  // Reference model: a TLP gets a slot iff fewer than two records are held at SOF.
  always @(posedge clk156) begin
    logic [63:0] w;
    bit tr;
    if (sys_rst) begin
      exp_q.delete();
      occ = 0; wpos = 0; m_inpkt = 0; m_cap = 0;
      m_pushed = 0; m_drop = 0; m_trunc = 0;
    end else if (bus.s_axis_tvalid) begin
      if (!m_inpkt) begin
        m_cap = 0;
        if (enable) begin
          if (occ < 2) begin
            m_cap = 1; occ++; m_nb = 0; m_err = 0;
            foreach (m_bytes[i]) m_bytes[i] = 8'h00;
          end else begin
            m_drop++;
          end
        end
      end
      if (m_cap) begin
        if (m_nb < REC)
          for (int b = 0; b < 8; b++)
            if (bus.s_axis_tkeep[b]) m_bytes[m_nb*8+b] = bus.s_axis_tdata[8*b +: 8];
        m_nb++;
        if (bus.s_axis_tuser) m_err = 1;
      end
      m_inpkt = !bus.s_axis_tlast;
      if (bus.s_axis_tlast && m_cap) begin
        tr = (m_nb > REC);
        for (int i = 0; i < REC; i++) begin
          for (int j = 0; j < 8; j++) w[63-8*j -: 8] = m_bytes[8*i+j];
          exp_q.push_back({8'hFF, w, (i == REC-1), (i == REC-1) && (m_err || tr)});
        end
        m_pushed++;
        if (tr) m_trunc++;
        m_cap = 0;
      end
    end
  end

  always @(negedge clk156) begin
    logic [73:0] e;
    if (bus.full) chk("wr_en_while_full", bus.wr_en, 1'b0);
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: din=%h with nothing expected", bus.din);
      end else begin
        e = exp_q.pop_front();
        chk("din", bus.din, e);
        if (wpos == 0) begin first_cyc = cyc; first_din = bus.din; end
        wpos++;
        if (e[1]) begin last_cyc = cyc; last_din = bus.din; wpos = 0; occ--; end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk156); #1;
      if (rand_bp) begin
        bus.full      = ($urandom_range(0, 4) == 0);
        bus.prog_full = ($urandom_range(0, 9) == 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk156); #1; end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = d; bus.s_axis_tkeep = k;
    bus.s_axis_tlast  = l;    bus.s_axis_tuser = u;
    @(posedge clk156); #1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
  endtask

  task automatic send_tlp(input int nb, input logic [7:0] lkeep, input logic [15:0] umask,
                          input bit rnd, input logic [7:0] base);
    for (int i = 0; i < nb; i++) begin
      logic [63:0] d;
      if (rnd) d = {$urandom, $urandom};
      else for (int b = 0; b < 8; b++) d[8*b +: 8] = base + 8'(8*i + b);
      beat(d, (i == nb-1) ? lkeep : 8'hFF, (i == nb-1), umask[i]);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_inpkt) && n < 400) begin idle(1); n++; end
    idle(3);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int tl;
    sys_rst = 1'b1; enable = 1'b1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
    bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0; bus.full = 1'b0; bus.prog_full = 1'b0;
    idle(3);
    sys_rst = 1'b0;
    @(negedge clk156);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_din", bus.din, 74'd0);
    chk("rst_cnt_tlp", cnt_tlp, 0);
    chk("rst_cnt_drop", cnt_drop, 0);
    chk("rst_cnt_trunc", cnt_trunc, 0);
    idle(1);

    send_tlp(4, 8'hFF, 16'h0, 1'b0, 8'h00);
    tl = cyc - 1;
    wait_drain("t1");
    chk("t1_latency", first_cyc - tl, 2);
    chk("t1_burst_len", last_cyc - first_cyc, REC - 1);
    chk("t1_first_din", first_din, {8'hFF, 64'h0001020304050607, 1'b0, 1'b0});
    chk("t1_cnt_tlp", cnt_tlp, 1);

    send_tlp(2, 8'h0F, 16'h0, 1'b0, 8'h40);
    wait_drain("t2");
    chk("t2_first_din", first_din, {8'hFF, 64'h4041424344454647, 1'b0, 1'b0});
    chk("t2_last_din", last_din, {8'hFF, 64'h0, 1'b1, 1'b0});

    send_tlp(6, 8'hFF, 16'h0, 1'b0, 8'h80);
    wait_drain("t3");
    chk("t3_cnt_trunc", cnt_trunc, 1);
    chk("t3_last_din", last_din, {8'hFF, 64'h98999A9B9C9D9E9F, 1'b1, 1'b1});

    bus.prog_full = 1'b1;
    send_tlp(2, 8'hFF, 16'h0, 1'b0, 8'h10);
    send_tlp(2, 8'hFF, 16'h0, 1'b0, 8'h20);
    send_tlp(2, 8'hFF, 16'h0, 1'b0, 8'h30);
    idle(4);
    chk("t4_cnt_drop", cnt_drop, 1);
    chk("t4_held_beats", exp_q.size(), 2 * REC);
    bus.prog_full = 1'b0;
    wait_drain("t4");
    chk("t4_cnt_tlp", cnt_tlp, 5);

    send_tlp(4, 8'hFF, 16'h0, 1'b0, 8'hC0);
    idle(2);
    bus.full = 1'b1;
    idle(1);
    bus.full = 1'b0;
    wait_drain("t5");
    chk("t5_burst_len", last_cyc - first_cyc, REC);
    chk("t5_cnt_tlp", cnt_tlp, 6);

    send_tlp(4, 8'hFF, 16'h0, 1'b0, 8'hE0);
    idle(3);
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    @(negedge clk156);
    chk("t6_wr_en_after_rst", bus.wr_en, 1'b0);
    chk("t6_cnt_tlp", cnt_tlp, 0);
    chk("t6_cnt_drop", cnt_drop, 0);
    chk("t6_cnt_trunc", cnt_trunc, 0);
    idle(1);
    send_tlp(3, 8'h3F, 16'h0, 1'b0, 8'h50);
    wait_drain("t6");
    chk("t6_cnt_tlp_after", cnt_tlp, 1);

    rand_bp = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int nb;
      nb = $urandom_range(1, 6);
      enable = ($urandom_range(0, 9) != 0);
      send_tlp(nb, 8'($urandom_range(1, 255)),
               ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, nb - 1)) : 16'h0,
               1'b1, 8'h00);
      idle($urandom_range(0, 3));
    end
    rand_bp = 1'b0;
    bus.full = 1'b0; bus.prog_full = 1'b0; enable = 1'b1;
    wait_drain("rnd");
    chk("rnd_cnt_tlp", cnt_tlp, m_pushed);
    chk("rnd_cnt_drop", cnt_drop, m_drop);
    chk("rnd_cnt_trunc", cnt_trunc, m_trunc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
